mpram_port_arbiter: RTL and testbench

MPRAM_PORT_ARBITER -- requirements
Module: mpram_port_arbiter

---
 rtl/mpram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mpram_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpram_port_arbiter.sv
// mpram_port_arbiter
// Four requesters share one 2-write/2-read memory. Each cycle, a round-robin
// scan grants up to two reads and up to two writes. The first grant of each
// kind goes to memory port 0 and the second to port 1. Each read port records
// which requester it served, so the response can be returned to that
// requester one cycle later.
//
// Optional feature:
//   WR_COLLISION_SERIALIZE_EN - when defined, two writes to the same address
//   are never granted in the same cycle. The later one in scan order waits.
//   When undefined, both are granted, and write port 1 (the later one in scan
//   order) determines the final memory content.
module mpram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [3:0]                       req_valid,
  input  logic [3:0]                       req_we,
  input  logic [3:0][ADDR_WIDTH-1:0]       req_addr,
  input  logic [3:0][DATA_WIDTH-1:0]       req_wdata,
  output logic [3:0]                       req_ready,
  output logic [3:0]                       rsp_valid,
  output logic [3:0][DATA_WIDTH-1:0]       rsp_data,
  output logic [1:0][ADDR_WIDTH-1:0]       mem_rdAddr,
  output logic [1:0][ADDR_WIDTH-1:0]       mem_wrAddr,
  output logic [1:0][DATA_WIDTH-1:0]       mem_dIn,
  output logic [1:0]                       mem_wren,
  input  logic [1:0][DATA_WIDTH-1:0]       mem_dOut
);

  logic [1:0]                 r_rr_ptr;
  logic [1:0][1:0]            r_rd_tag;
  logic [1:0]                 r_rd_vld;

  logic [3:0]                 w_ready;
  logic [1:0][ADDR_WIDTH-1:0] w_rd_addr;
  logic [1:0][ADDR_WIDTH-1:0] w_wr_addr;
  logic [1:0][DATA_WIDTH-1:0] w_din;
  logic [1:0]                 w_wren;
  logic [1:0]                 w_rd_en;
  logic [1:0][1:0]            w_rd_tag;
  logic                       w_any;
  logic [1:0]                 w_last;
  logic [1:0]                 w_rd_cnt;
  logic [1:0]                 w_wr_cnt;
  logic [1:0]                 w_idx;
  logic                       w_collide;

  // Round-robin scan from r_rr_ptr: hand out read and write slots in scan order.
  // NOTE: combinational blocks use blocking '=' so that later loop iterations
  // see the slot counters as updated by earlier iterations.
  always_comb begin
    w_ready   = '0;
    w_rd_addr = '0;
    w_wr_addr = '0;
    w_din     = '0;
    w_wren    = '0;
    w_rd_en   = '0;
    w_rd_tag  = '0;
    w_any     = 1'b0;
    w_last    = '0;
    w_rd_cnt  = '0;
    w_wr_cnt  = '0;
    w_idx     = '0;
    w_collide = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_idx     = r_rr_ptr + 2'(i);
      w_collide = 1'b0;
      // No grants while reset is held low, so memory writes stay disabled.
      if (reset && req_valid[w_idx]) begin
        if (!req_we[w_idx]) begin
          if (w_rd_cnt < 2'd2) begin
            w_rd_addr[w_rd_cnt[0]] = req_addr[w_idx];
            w_rd_en[w_rd_cnt[0]]   = 1'b1;
            w_rd_tag[w_rd_cnt[0]]  = w_idx;
            w_ready[w_idx]         = 1'b1;
            w_any                  = 1'b1;
            w_last                 = w_idx;
            w_rd_cnt               = w_rd_cnt + 2'd1;
          end
        end else if (w_wr_cnt < 2'd2) begin
`ifdef WR_COLLISION_SERIALIZE_EN
          w_collide = (w_wr_cnt == 2'd1) && (w_wr_addr[0] == req_addr[w_idx]);
`endif
          if (!w_collide) begin
            w_wr_addr[w_wr_cnt[0]] = req_addr[w_idx];
            w_din[w_wr_cnt[0]]     = req_wdata[w_idx];
            w_wren[w_wr_cnt[0]]    = 1'b1;
            w_ready[w_idx]         = 1'b1;
            w_any                  = 1'b1;
            w_last                 = w_idx;
            w_wr_cnt               = w_wr_cnt + 2'd1;
          end
        end
      end
    end
  end

  assign req_ready  = w_ready;
  assign mem_rdAddr = w_rd_addr;
  assign mem_wrAddr = w_wr_addr;
  assign mem_dIn    = w_din;
  assign mem_wren   = w_wren;

  // Move the pointer past the last grant, and record read tags so that
  // responses can be steered back to their requesters.
  // NOTE: asynchronous reset clears the in-flight read tags immediately, so no
  // response from before reset can appear after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_rd_vld <= '0;
      r_rd_tag <= '0;
    end else begin
      if (w_any) r_rr_ptr <= w_last + 2'd1;
      r_rd_vld <= w_rd_en;
      r_rd_tag <= w_rd_tag;
    end
  end

  // Route each valid read port's data to its tagged requester; all others read 0.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int p = 0; p < 2; p++) begin
      if (r_rd_vld[p]) begin
        rsp_valid[r_rd_tag[p]] = 1'b1;
        rsp_data[r_rd_tag[p]]  = mem_dOut[p];
      end
    end
  end

endmodule

// File: tb/tb_mpram_port_arbiter.sv
// Directed testbench for mpram_port_arbiter. A behavioural 2W2R memory is
// attached. Its read data is registered one cycle after the address, and
// write port 1 is applied after write port 0.
module tb_mpram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 5;

  logic                     clk;
  logic                     reset;
  logic [3:0]               req_valid;
  logic [3:0]               req_we;
  logic [3:0][AW-1:0]       req_addr;
  logic [3:0][DW-1:0]       req_wdata;
  logic [3:0]               req_ready;
  logic [3:0]               rsp_valid;
  logic [3:0][DW-1:0]       rsp_data;
  logic [1:0][AW-1:0]       mem_rdAddr;
  logic [1:0][AW-1:0]       mem_wrAddr;
  logic [1:0][DW-1:0]       mem_dIn;
  logic [1:0]               mem_wren;
  logic [1:0][DW-1:0]       mem_dOut;

  logic [DW-1:0]            mem [2**AW];
  logic                     pre_en;
  logic [AW-1:0]            pre_addr;
  logic [DW-1:0]            pre_data;

  int total = 0;
  int bad   = 0;

  mpram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .mem_rdAddr (mem_rdAddr),
    .mem_wrAddr (mem_wrAddr),
    .mem_dIn    (mem_dIn),
    .mem_wren   (mem_wren),
    .mem_dOut   (mem_dOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: reads return the pre-write contents, and port 1 wins on a
  // write collision.
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    mem_dOut[0] <= mem[mem_rdAddr[0]];
    mem_dOut[1] <= mem[mem_rdAddr[1]];
    if (mem_wren[0]) mem[mem_wrAddr[0]] <= mem_dIn[0];
    if (mem_wren[1]) mem[mem_wrAddr[1]] <= mem_dIn[1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_en   = 1'b0;
  endtask

  task automatic idle;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  initial begin
    reset    = 1'b0;
    pre_en   = 1'b0;
    pre_addr = '0;
    pre_data = '0;
    idle();

    // Reset held low with write requests present: no grants and no writes.
    req_valid = 4'b0011;
    req_we    = 4'b0011;
    #2;
    check("rst_ready",    32'(req_ready), 32'h0);
    check("rst_wren",     32'(mem_wren),  32'h0);
    check("rst_rsp_vld",  32'(rsp_valid), 32'h0);
    tick();
    check("rst_rr_ptr",   32'(dut.r_rr_ptr), 32'h0);
    idle();
    reset = 1'b1;

    // Single read of a preloaded word.
    preload(5'd3, 8'hA5);
    req_valid = 4'b0001;
    req_addr[0] = 5'd3;
    #1;
    check("single_ready",  32'(req_ready),     32'h1);
    check("single_rdaddr", 32'(mem_rdAddr[0]), 32'h3);
    tick();
    idle();
    check("single_rsp_vld",  32'(rsp_valid), 32'h1);
    check("single_rsp_data", 32'(rsp_data),  32'h0000_00A5);
    check("single_rr_ptr",   32'(dut.r_rr_ptr), 32'h1);
    tick();
    check("single_rsp_once", 32'(rsp_valid), 32'h0);

    // Requester 2 read granted, then reset pulsed: response must be discarded.
    req_valid = 4'b0100;
    req_addr[2] = 5'd3;
    #1;
    check("flight_ready", 32'(req_ready), 32'h4);
    tick();
    idle();
    reset = 1'b0;
    #2;
    check("flight_rsp_in_rst", 32'(rsp_valid), 32'h0);
    reset = 1'b1;
    #1;
    check("flight_rsp_release", 32'(rsp_valid), 32'h0);
    check("flight_rr_ptr",      32'(dut.r_rr_ptr), 32'h0);
    tick();
    check("flight_rsp_after", 32'(rsp_valid), 32'h0);

    // All four requesters read: two grants per cycle, round-robin.
    preload(5'd10, 8'h10);
    preload(5'd11, 8'h11);
    preload(5'd12, 8'h12);
    preload(5'd13, 8'h13);
    req_valid = 4'b1111;
    req_addr  = {5'd13, 5'd12, 5'd11, 5'd10};
    #1;
    check("all4_c1_ready",  32'(req_ready),  32'h3);
    check("all4_c1_rdaddr", 32'(mem_rdAddr), 32'h0000_016A);
    tick();
    req_valid = 4'b1100;
    check("all4_c1_rr_ptr",  32'(dut.r_rr_ptr), 32'h2);
    check("all4_c1_rsp_vld", 32'(rsp_valid), 32'h3);
    check("all4_c1_rsp",     32'(rsp_data),  32'h0000_1110);
    #1;
    check("all4_c2_ready", 32'(req_ready), 32'hC);
    tick();
    idle();
    check("all4_c2_rr_ptr",  32'(dut.r_rr_ptr), 32'h0);
    check("all4_c2_rsp_vld", 32'(rsp_valid), 32'hC);
    check("all4_c2_rsp",     32'(rsp_data),  32'h1312_0000);

    // Write and read of the same address in the same cycle: the read returns the old value.
    preload(5'd4, 8'h33);
    req_valid    = 4'b0011;
    req_we       = 4'b0001;
    req_addr[0]  = 5'd4;
    req_wdata[0] = 8'h5A;
    req_addr[1]  = 5'd4;
    #1;
    check("rw_ready",  32'(req_ready),     32'h3);
    check("rw_wren",   32'(mem_wren),      32'h1);
    check("rw_din",    32'(mem_dIn[0]),    32'h5A);
    check("rw_wraddr", 32'(mem_wrAddr[0]), 32'h4);
    tick();
    idle();
    check("rw_old_vld",  32'(rsp_valid), 32'h2);
    check("rw_old_data", 32'(rsp_data),  32'h0000_3300);
    req_valid   = 4'b0010;
    req_addr[1] = 5'd4;
    #1;
    check("rw_reread_ready", 32'(req_ready), 32'h2);
    tick();
    idle();
    check("rw_new_data", 32'(rsp_data), 32'h0000_5A00);

    // Reset again so that the write-collision test starts with rr_ptr = 0.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();

    // Requesters 1 and 2 both write address 7.
    req_valid    = 4'b0110;
    req_we       = 4'b0110;
    req_addr[1]  = 5'd7;
    req_addr[2]  = 5'd7;
    req_wdata[1] = 8'h11;
    req_wdata[2] = 8'h22;
    #1;
`ifdef WR_COLLISION_SERIALIZE_EN
    check("coll_c1_ready", 32'(req_ready), 32'h2);
    check("coll_c1_wren",  32'(mem_wren),  32'h1);
    check("coll_c1_din",   32'(mem_dIn[0]), 32'h11);
    tick();
    req_valid = 4'b0100;
    check("coll_c1_rr_ptr", 32'(dut.r_rr_ptr), 32'h2);
    #1;
    check("coll_c2_ready", 32'(req_ready), 32'h4);
    check("coll_c2_din",   32'(mem_dIn[0]), 32'h22);
    tick();
    idle();
`else
    check("coll_ready", 32'(req_ready), 32'h6);
    check("coll_wren",  32'(mem_wren),  32'h3);
    check("coll_din",   32'(mem_dIn),   32'h2211);
    check("coll_wraddr", 32'(mem_wrAddr), 32'h0000_00E7);
    tick();
    idle();
`endif
    check("coll_rr_ptr", 32'(dut.r_rr_ptr), 32'h3);
    req_valid   = 4'b0001;
    req_addr[0] = 5'd7;
    #1;
    check("coll_read_ready", 32'(req_ready), 32'h1);
    tick();
    idle();
    check("coll_read_vld",  32'(rsp_valid), 32'h1);
    check("coll_read_data", 32'(rsp_data),  32'h0000_0022);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
